// File: rtl/nonce_result_tracker.sv
// Consumer side of the nonce generator: issues nonces to the hash core, tracks
// them in an in-flight FIFO and matches in-order results against the job target.
module nonce_result_tracker #(
  parameter int DEPTH  = 8,
  parameter int HASH_W = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_start,
  input  logic [HASH_W-1:0]          target,
  input  logic [31:0]                nonce,
  input  logic                       nonce_overflow,
  output logic                       gen_enable,
  output logic                       gen_restart,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [31:0]                issue_nonce,
  input  logic                       result_valid,
  input  logic [HASH_W-1:0]          result_hash,
  output logic                       found,
  output logic [31:0]                golden_nonce,
  output logic                       exhausted,
  output logic                       busy,
  output logic                       proto_err,
  output logic [$clog2(DEPTH):0]     inflight_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_RESTART, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [HASH_W-1:0] target_q, target_d;
  logic [31:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              last_issued_q, last_issued_d;
  logic              found_q, found_d;
  logic              exhausted_q, exhausted_d;
  logic              proto_err_q, proto_err_d;
  logic [31:0]       golden_q, golden_d;

  logic fifo_full, fifo_empty, handshake, pop, hit, job_accept;
  logic [31:0] head_nonce;

  assign fifo_full   = (count_q == CNT_W'(DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign issue_valid = (state_q == S_ISSUE) && !fifo_full && !last_issued_q;
  assign handshake   = issue_valid && issue_ready;
  // The generator must never wrap, so the final nonce is issued without an enable.
  assign gen_enable  = handshake && !nonce_overflow;
  assign gen_restart = (state_q == S_RESTART);
  assign busy        = (state_q == S_RESTART) || (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign issue_nonce = nonce;
  assign job_accept  = job_start && ((state_q == S_IDLE) || ((state_q == S_DONE) && fifo_empty));
  assign pop         = result_valid && !fifo_empty;
  assign head_nonce  = fifo_mem[rd_ptr_q];
  assign hit         = pop && (result_hash < target_q);

  assign found          = found_q;
  assign golden_nonce   = golden_q;
  assign exhausted      = exhausted_q;
  assign proto_err      = proto_err_q;
  assign inflight_count = count_q;

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    wr_ptr_d      = handshake ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d       = count_q + CNT_W'(handshake) - CNT_W'(pop);
    last_issued_d = last_issued_q;
    found_d       = found_q;
    exhausted_d   = exhausted_q;
    proto_err_d   = proto_err_q || (result_valid && fifo_empty);
    golden_d      = golden_q;

    case (state_q)
      S_RESTART: state_d = S_ISSUE;
      S_ISSUE: begin
        if (handshake && nonce_overflow) begin
          last_issued_d = 1'b1;
          state_d       = S_DRAIN;
        end
        if (hit) begin
          golden_d = head_nonce;
          found_d  = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DRAIN: begin
        if (hit) begin
          golden_d = head_nonce;
          found_d  = 1'b1;
          state_d  = S_DONE;
        end else if (fifo_empty) begin
          exhausted_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      default: ;
    endcase

    if (job_accept) begin
      state_d       = S_RESTART;
      target_d      = target;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      last_issued_d = 1'b0;
      found_d       = 1'b0;
      exhausted_d   = 1'b0;
      proto_err_d   = 1'b0;
      golden_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (handshake) fifo_mem[wr_ptr_q] <= nonce;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      target_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      last_issued_q <= 1'b0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      proto_err_q   <= 1'b0;
      golden_q      <= '0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      last_issued_q <= last_issued_d;
      found_q       <= found_d;
      exhausted_q   <= exhausted_d;
      proto_err_q   <= proto_err_d;
      golden_q      <= golden_d;
    end
  end
endmodule

// File: tb/tb_nonce_result_tracker.sv
// Bench for nonce_result_tracker: generator and hash-core models around the DUT,
// expected issue order kept in a queue and checked as handshakes occur.
module tb_nonce_result_tracker;
  localparam int DEPTH  = 8;
  localparam int HASH_W = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, job_start, nonce_overflow, gen_enable, gen_restart;
  logic              issue_valid, issue_ready, result_valid, found, exhausted, busy, proto_err;
  logic [HASH_W-1:0] target, result_hash;
  logic [31:0]       nonce, issue_nonce, golden_nonce;
  logic [$clog2(DEPTH):0] inflight_count;

  nonce_result_tracker #(.DEPTH(DEPTH), .HASH_W(HASH_W)) dut (
    .clk(clk), .rst(rst), .job_start(job_start), .target(target), .nonce(nonce),
    .nonce_overflow(nonce_overflow), .gen_enable(gen_enable), .gen_restart(gen_restart),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_nonce(issue_nonce),
    .result_valid(result_valid), .result_hash(result_hash), .found(found),
    .golden_nonce(golden_nonce), .exhausted(exhausted), .busy(busy),
    .proto_err(proto_err), .inflight_count(inflight_count)
  );

  // Generator model; preload lets a test jump near the top of the nonce space.
  logic [31:0] gen_nonce, preload_val;
  logic        preload_req;
  always @(posedge clk) begin
    if (rst) gen_nonce <= '0;
    else if (preload_req) gen_nonce <= preload_val;
    else if (gen_restart) gen_nonce <= '0;
    else if (gen_enable) gen_nonce <= gen_nonce + 32'd1;
  end
  assign nonce          = gen_nonce;
  assign nonce_overflow = (gen_nonce == 32'hFFFFFFFF);

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] core_q[$];
  logic        tb_ready, core_on, hit_en;
  logic [31:0] hit_nonce, eq_nonce;
  logic [HASH_W-1:0] tgt_c;

  function automatic logic [HASH_W-1:0] hash_of(input logic [31:0] n);
    if (hit_en && n == hit_nonce) return HASH_W'(5);
    if (n == eq_nonce) return tgt_c;
    return '1;
  endfunction

  task automatic run(input int n);
    logic [31:0] rn, in_n, en;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (core_on && core_q.size() > 0) begin
        rn = core_q.pop_front();
        result_valid = 1'b1;
        result_hash  = hash_of(rn);
      end else begin
        result_valid = 1'b0;
        result_hash  = '0;
      end
      issue_ready = tb_ready;
      #1;
      if (issue_valid && issue_ready) begin
        in_n = issue_nonce;
        $display("issue nonce=%08h inflight=%0d", in_n, inflight_count);
        checks++;
        if (exp_q.size() == 0) $display("FAIL issue_unexpected got=%08h want=none", in_n);
        else begin
          en = exp_q.pop_front();
          if (in_n !== en) $display("FAIL issue_order got=%08h want=%08h", in_n, en);
          else passed++;
        end
        checks++;
        if (gen_enable !== (in_n != 32'hFFFFFFFF))
          $display("FAIL gen_enable_on_issue got=%0b want=%0b", gen_enable, in_n != 32'hFFFFFFFF);
        else passed++;
        core_q.push_back(in_n);
      end else begin
        checks++;
        if (gen_enable !== 1'b0) $display("FAIL gen_enable_idle got=%0b want=0", gen_enable);
        else passed++;
      end
    end
  endtask

  task automatic quiesce();
    @(negedge clk);
    result_valid = 1'b0;
    issue_ready  = 1'b0;
    job_start    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; result_valid = 1'b0; issue_ready = 1'b0; job_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    core_q.delete();
    exp_q.delete();
  endtask

  task automatic start_job(input logic [31:0] pre, input bit use_pre);
    @(negedge clk);
    result_valid = 1'b0; issue_ready = 1'b0; target = tgt_c; job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    checks++;
    if (gen_restart !== 1'b1) $display("FAIL restart_pulse got=%0b want=1", gen_restart); else passed++;
    checks++;
    if (busy !== 1'b1) $display("FAIL restart_busy got=%0b want=1", busy); else passed++;
    $display("job start target=%064h", tgt_c);
    if (use_pre) begin preload_req = 1'b1; preload_val = pre; end
    @(negedge clk);
    preload_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({found, exhausted, proto_err, busy, issue_valid, gen_enable, gen_restart} !== 7'b0)
      $display("FAIL reset_flags got=%07b want=0000000",
               {found, exhausted, proto_err, busy, issue_valid, gen_enable, gen_restart});
    else passed++;
    checks++;
    if (inflight_count !== '0) $display("FAIL reset_count got=%0d want=0", inflight_count); else passed++;
    checks++;
    if (golden_nonce !== 32'd0) $display("FAIL reset_golden got=%08h want=0", golden_nonce); else passed++;
  endtask

  task automatic test_basic_hit();
    hit_en = 1'b1; hit_nonce = 32'd5; eq_nonce = 32'd2;
    for (int i = 0; i <= 6; i++) exp_q.push_back(32'(i));
    start_job(32'd0, 1'b0);
    tb_ready = 1'b1; core_on = 1'b1;
    run(20);
    quiesce();
    checks++;
    if (exp_q.size() != 0) $display("FAIL hit_issue_count got=%0d left want=0", exp_q.size()); else passed++;
    checks++;
    if (found !== 1'b1 || exhausted !== 1'b0) $display("FAIL hit_flags got=%0b%0b want=10", found, exhausted); else passed++;
    checks++;
    if (golden_nonce !== 32'd5) $display("FAIL hit_golden got=%08h want=00000005", golden_nonce); else passed++;
    checks++;
    if (busy !== 1'b0 || issue_valid !== 1'b0) $display("FAIL hit_idle got=%0b%0b want=00", busy, issue_valid); else passed++;
    checks++;
    if (inflight_count !== '0) $display("FAIL hit_drained got=%0d want=0", inflight_count); else passed++;
  endtask

  task automatic test_backpressure();
    hit_en = 1'b0; eq_nonce = 32'h12345678;
    for (int i = 0; i <= 8; i++) exp_q.push_back(32'(i));
    start_job(32'd0, 1'b0);
    tb_ready = 1'b1; core_on = 1'b0;
    run(12);
    checks++;
    if (inflight_count !== 4'd8) $display("FAIL full_count got=%0d want=8", inflight_count); else passed++;
    checks++;
    if (issue_valid !== 1'b0) $display("FAIL full_valid got=%0b want=0", issue_valid); else passed++;
    core_on = 1'b1;
    run(1);
    core_on = 1'b0;
    run(3);
    quiesce();
    checks++;
    if (exp_q.size() != 0) $display("FAIL refill_issue got=%0d left want=0", exp_q.size()); else passed++;
    checks++;
    if (inflight_count !== 4'd8) $display("FAIL refill_count got=%0d want=8", inflight_count); else passed++;
    do_reset();
  endtask

  task automatic test_top_of_space(input bit hit_last);
    hit_en = hit_last; hit_nonce = 32'hFFFFFFFF; eq_nonce = 32'h12345678;
    exp_q.push_back(32'hFFFFFFFD); exp_q.push_back(32'hFFFFFFFE); exp_q.push_back(32'hFFFFFFFF);
    start_job(32'hFFFFFFFD, 1'b1);
    tb_ready = 1'b1; core_on = 1'b1;
    run(10);
    quiesce();
    checks++;
    if (exp_q.size() != 0) $display("FAIL top_issue_count got=%0d left want=0", exp_q.size()); else passed++;
    checks++;
    if (found !== hit_last || exhausted !== !hit_last)
      $display("FAIL top_flags got=%0b%0b want=%0b%0b", found, exhausted, hit_last, !hit_last);
    else passed++;
    checks++;
    if (golden_nonce !== (hit_last ? 32'hFFFFFFFF : 32'd0))
      $display("FAIL top_golden got=%08h want=%08h", golden_nonce, hit_last ? 32'hFFFFFFFF : 32'd0);
    else passed++;
    checks++;
    if (busy !== 1'b0 || inflight_count !== '0) $display("FAIL top_done got=%0b/%0d want=0/0", busy, inflight_count); else passed++;
  endtask

  task automatic test_proto_gating();
    do_reset();
    @(negedge clk); result_valid = 1'b1; result_hash = '1;
    @(negedge clk); result_valid = 1'b0;
    checks++;
    if (proto_err !== 1'b1 || busy !== 1'b0) $display("FAIL proto_set got=%0b%0b want=10", proto_err, busy); else passed++;
    hit_en = 1'b1; hit_nonce = 32'd0; eq_nonce = 32'h12345678;
    for (int i = 0; i <= 2; i++) exp_q.push_back(32'(i));
    start_job(32'd0, 1'b0);
    checks++;
    if (proto_err !== 1'b0) $display("FAIL proto_clear got=%0b want=0", proto_err); else passed++;
    tb_ready = 1'b1; core_on = 1'b0; run(3);
    tb_ready = 1'b0; core_on = 1'b1; run(1);
    quiesce();
    checks++;
    if (found !== 1'b1 || golden_nonce !== 32'd0 || inflight_count !== 4'd2)
      $display("FAIL gate_done got=%0b/%08h/%0d want=1/00000000/2", found, golden_nonce, inflight_count);
    else passed++;
    job_start = 1'b1;
    @(negedge clk); job_start = 1'b0;
    checks++;
    if (gen_restart !== 1'b0 || busy !== 1'b0 || found !== 1'b1)
      $display("FAIL gate_ignore got=%0b%0b%0b want=001", gen_restart, busy, found);
    else passed++;
    run(3);
    quiesce();
    checks++;
    if (inflight_count !== '0) $display("FAIL gate_drain got=%0d want=0", inflight_count); else passed++;
    start_job(32'd0, 1'b0);
    checks++;
    if (found !== 1'b0 || golden_nonce !== 32'd0) $display("FAIL gate_restart got=%0b/%08h want=0/0", found, golden_nonce); else passed++;
    do_reset();
  endtask

  task automatic test_reset_midjob();
    hit_en = 1'b0; eq_nonce = 32'h12345678;
    for (int i = 0; i <= 2; i++) exp_q.push_back(32'(i));
    start_job(32'd0, 1'b0);
    tb_ready = 1'b1; core_on = 1'b0; run(3);
    @(negedge clk);
    checks++;
    if (inflight_count !== 4'd3) $display("FAIL mid_count got=%0d want=3", inflight_count); else passed++;
    rst = 1'b1; issue_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (inflight_count !== '0 || busy !== 1'b0 || issue_valid !== 1'b0)
      $display("FAIL mid_reset got=%0d/%0b/%0b want=0/0/0", inflight_count, busy, issue_valid);
    else passed++;
    checks++;
    if ({found, exhausted, proto_err} !== 3'b0) $display("FAIL mid_sticky got=%03b want=000", {found, exhausted, proto_err}); else passed++;
    core_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; job_start = 1'b0; issue_ready = 1'b0; result_valid = 1'b0;
    result_hash = '0; target = '0; preload_req = 1'b0; preload_val = '0;
    tb_ready = 1'b0; core_on = 1'b0; hit_en = 1'b0; hit_nonce = '0; eq_nonce = 32'h12345678;
    tgt_c = '0; tgt_c[HASH_W-1] = 1'b1;
    test_reset();
    test_basic_hit();
    test_backpressure();
    test_top_of_space(1'b0);
    test_top_of_space(1'b1);
    test_proto_gating();
    test_reset_midjob();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
